// File: rtl/zrb_sram_responder.sv
// SRAM-style slave: latched writes with byte lanes, fixed-latency reads, sticky protocol error.
// Access counters are built only when ZRB_SRAM_RESPONDER_STATS_EN is defined.
module zrb_sram_responder #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned READ_LAT       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] sram_adr,
    input  logic [15:0] sram_dat_i,
    output logic [15:0] sram_dat_o,
    output logic        sram_dat_oe,
    input  logic        sram_we,
    input  logic        sram_ce,
    input  logic        sram_oe,
    input  logic        sram_lb,
    input  logic        sram_ub,
    output logic        err_protocol
`ifdef ZRB_SRAM_RESPONDER_STATS_EN
    ,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
`endif
);
    localparam int unsigned AW    = MEM_ADDR_WIDTH;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = 3;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DRIVE} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lat_cnt, lat_cnt_nxt;
    logic [AW-1:0] rd_adr, rd_adr_nxt;
    logic [AW-1:0] wr_adr, wr_adr_nxt;
    logic [DW-1:0] wr_dat, wr_dat_nxt;
    logic          wr_lb, wr_lb_nxt;
    logic          wr_ub, wr_ub_nxt;
    logic [DW-1:0] dat_o_nxt;
    logic          dat_oe_nxt;
    logic          err_nxt;
    logic          go_write_c, go_read_c;
    logic          commit_c, rd_enter_c;
    logic          wr_req_c, rd_req_c;
    logic [AW-1:0] adr_c;
    logic [DW-1:0] rd_word_c;
    logic [DW-1:0] mem [DEPTH];

    assign adr_c    = sram_adr[AW-1:0];
    assign wr_req_c = !sram_ce && !sram_we;
    assign rd_req_c = !sram_ce && sram_we && !sram_oe;
    // A commit always lands at least one edge before the earliest drive, so reads see new data.
    assign rd_word_c = {sram_ub ? 8'h00 : mem[adr_c][15:8],
                        sram_lb ? 8'h00 : mem[adr_c][7:0]};

    // Next-state and registered-output decode
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        rd_adr_nxt  = rd_adr;
        wr_adr_nxt  = wr_adr;
        wr_dat_nxt  = wr_dat;
        wr_lb_nxt   = wr_lb;
        wr_ub_nxt   = wr_ub;
        dat_o_nxt   = '0;
        dat_oe_nxt  = 1'b0;
        err_nxt     = err_protocol;
        go_write_c  = 1'b0;
        go_read_c   = 1'b0;
        commit_c    = 1'b0;
        rd_enter_c  = 1'b0;

        case (state)
            IDLE: begin
                if (wr_req_c) begin
                    go_write_c = 1'b1;
                end else if (rd_req_c) begin
                    go_read_c = 1'b1;
                end
            end
            WRITE: begin
                if (sram_we || sram_ce) begin
                    commit_c = 1'b1;
                    if (rd_req_c) begin
                        go_read_c = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wr_dat_nxt = sram_dat_i;
                    wr_lb_nxt  = sram_lb;
                    wr_ub_nxt  = sram_ub;
                    if (adr_c != wr_adr) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            READ_WAIT, READ_DRIVE: begin
                if (sram_ce || (sram_we && sram_oe)) begin
                    state_nxt = IDLE;
                end else if (!sram_we) begin
                    go_write_c = 1'b1;
                end else if (adr_c != rd_adr) begin
                    go_read_c = 1'b1;
                end else if (state == READ_DRIVE || lat_cnt == LW'(READ_LAT)) begin
                    state_nxt  = READ_DRIVE;
                    dat_oe_nxt = 1'b1;
                    dat_o_nxt  = rd_word_c;
                    rd_enter_c = (state == READ_WAIT);
                end else begin
                    lat_cnt_nxt = lat_cnt + LW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (go_write_c) begin
            state_nxt  = WRITE;
            wr_adr_nxt = adr_c;
            wr_dat_nxt = sram_dat_i;
            wr_lb_nxt  = sram_lb;
            wr_ub_nxt  = sram_ub;
        end
        // Latency counts the request sample itself as the first cycle
        if (go_read_c) begin
            state_nxt   = READ_WAIT;
            rd_adr_nxt  = adr_c;
            lat_cnt_nxt = LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            rd_adr       <= '0;
            wr_adr       <= '0;
            wr_dat       <= '0;
            wr_lb        <= 1'b1;
            wr_ub        <= 1'b1;
            sram_dat_o   <= '0;
            sram_dat_oe  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_cnt_nxt;
            rd_adr       <= rd_adr_nxt;
            wr_adr       <= wr_adr_nxt;
            wr_dat       <= wr_dat_nxt;
            wr_lb        <= wr_lb_nxt;
            wr_ub        <= wr_ub_nxt;
            sram_dat_o   <= dat_o_nxt;
            sram_dat_oe  <= dat_oe_nxt;
            err_protocol <= err_nxt;
        end
    end

    // Storage is deliberately outside reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        if (commit_c) begin
            if (!wr_lb) mem[wr_adr][7:0]  <= wr_dat[7:0];
            if (!wr_ub) mem[wr_adr][15:8] <= wr_dat[15:8];
        end
    end

`ifdef ZRB_SRAM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (commit_c)   wr_count <= wr_count + 16'd1;
            if (rd_enter_c) rd_count <= rd_count + 16'd1;
        end
    end
`else
    logic unused_stats_c;
    assign unused_stats_c = rd_enter_c;
`endif

    logic unused_adr_c;
    assign unused_adr_c = ^sram_adr;

endmodule

// File: tb/tb_zrb_sram_responder.sv
// Randomised self-checking bench for zrb_sram_responder against a word/lane memory model.
`timescale 1ns/1ps
module tb_zrb_sram_responder;
    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] sram_adr = '0;
    logic [15:0] sram_dat_i = '0;
    logic [15:0] sram_dat_o;
    logic        sram_dat_oe;
    logic        sram_we = 1'b1;
    logic        sram_ce = 1'b1;
    logic        sram_oe = 1'b1;
    logic        sram_lb = 1'b0;
    logic        sram_ub = 1'b0;
    logic        err_protocol;
`ifdef ZRB_SRAM_RESPONDER_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] model [int];

    zrb_sram_responder #(.MEM_ADDR_WIDTH(10), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .sram_adr(sram_adr), .sram_dat_i(sram_dat_i),
        .sram_dat_o(sram_dat_o), .sram_dat_oe(sram_dat_oe), .sram_we(sram_we),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_lb(sram_lb), .sram_ub(sram_ub),
        .err_protocol(err_protocol)
`ifdef ZRB_SRAM_RESPONDER_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        sram_ce = 1'b1;
        sram_we = 1'b1;
        sram_oe = 1'b1;
    endtask

    function automatic void model_write(int a, logic [15:0] d, logic lb, logic ub);
        logic [15:0] v;
        v = model.exists(a) ? model[a] : 16'h0000;
        if (!lb) v[7:0] = d[7:0];
        if (!ub) v[15:8] = d[15:8];
        model[a] = v;
    endfunction

    function automatic logic [15:0] model_read(int a, logic lb, logic ub);
        logic [15:0] v;
        v = model[a];
        if (lb) v[7:0] = 8'h00;
        if (ub) v[15:8] = 8'h00;
        return v;
    endfunction

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic lb, input logic ub, input int n);
        sram_adr = a; sram_dat_i = d; sram_lb = lb; sram_ub = ub;
        sram_ce = 1'b0; sram_we = 1'b0; sram_oe = 1'b1;
        repeat (n) cyc();
        go_idle();
        cyc();
        model_write(int'(a[9:0]), d, lb, ub);
    endtask

    // Returns cycles from the request sample to sram_dat_oe, or -1 on timeout
    task automatic do_read(input logic [17:0] a, input logic lb, input logic ub,
                           output int lat, output logic [15:0] d);
        lat = -1;
        d = '0;
        sram_adr = a; sram_lb = lb; sram_ub = ub;
        sram_ce = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (sram_dat_oe) begin
                lat = i - 1;
                d = sram_dat_o;
                break;
            end
        end
        go_idle();
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        go_idle();
        repeat (2) cyc();
        tests_run++;
        if (sram_dat_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", sram_dat_oe); end
        tests_run++;
        if (sram_dat_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_dat: got %h expected 0000", sram_dat_o); end
        tests_run++;
        if (err_protocol !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_protocol); end
`ifdef ZRB_SRAM_RESPONDER_STATS_EN
        tests_run++;
        if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
            tests_failed++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", wr_count, rd_count);
        end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] d;
        do_write(18'd5, 16'hA5C3, 1'b0, 1'b0, 3);
        do_read(18'd5, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (lat !== READ_LAT) begin tests_failed++; $display("FAIL wr_rd_latency: got %0d expected %0d", lat, READ_LAT); end
        tests_run++;
        if (d !== 16'hA5C3) begin tests_failed++; $display("FAIL wr_rd_data: got %h expected a5c3", d); end
    endtask

    task automatic test_lanes();
        int lat; logic [15:0] d;
        do_write(18'd5, 16'h1234, 1'b0, 1'b0, 1);
        do_write(18'd5, 16'hFFFF, 1'b0, 1'b1, 2);
        do_read(18'd5, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (d !== 16'h12FF) begin tests_failed++; $display("FAIL lanes_ub_write: got %h expected 12ff", d); end
        do_read(18'd5, 1'b1, 1'b0, lat, d);
        tests_run++;
        if (d !== 16'h1200) begin tests_failed++; $display("FAIL lanes_lb_read: got %h expected 1200", d); end
        do_write(18'd5, 16'h0000, 1'b1, 1'b1, 1);
        do_read(18'd5, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (d !== model_read(5, 1'b0, 1'b0)) begin
            tests_failed++; $display("FAIL lanes_none: got %h expected %h", d, model_read(5, 1'b0, 1'b0));
        end
    endtask

    task automatic test_addr_change();
        logic seen;
        do_write(18'd6, 16'h6C6C, 1'b0, 1'b0, 2);
        sram_adr = 18'd5; sram_lb = 1'b0; sram_ub = 1'b0;
        sram_ce = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = sram_dat_oe; end
        tests_run++;
        if (seen !== 1'b1 || sram_dat_o !== model_read(5, 1'b0, 1'b0)) begin
            tests_failed++; $display("FAIL achg_first: got oe=%b %h expected oe=1 %h", seen, sram_dat_o, model_read(5, 1'b0, 1'b0));
        end
        sram_adr = 18'd6;
        cyc();
        tests_run++;
        if (sram_dat_oe !== 1'b0) begin tests_failed++; $display("FAIL achg_drop1: got %b expected 0", sram_dat_oe); end
        cyc();
        tests_run++;
        if (sram_dat_oe !== 1'b0) begin tests_failed++; $display("FAIL achg_drop2: got %b expected 0", sram_dat_oe); end
        cyc();
        tests_run++;
        if (sram_dat_oe !== 1'b1 || sram_dat_o !== 16'h6C6C) begin
            tests_failed++; $display("FAIL achg_return: got oe=%b %h expected oe=1 6c6c", sram_dat_oe, sram_dat_o);
        end
        go_idle();
        cyc();
        tests_run++;
        if (sram_dat_oe !== 1'b0) begin tests_failed++; $display("FAIL read_release: got %b expected 0", sram_dat_oe); end
    endtask

    task automatic test_write_in_drive();
        int lat; logic [15:0] d; logic seen;
        do_write(18'd7, 16'h0707, 1'b0, 1'b0, 1);
        sram_adr = 18'd7; sram_lb = 1'b0; sram_ub = 1'b0;
        sram_ce = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = sram_dat_oe; end
        sram_we = 1'b0; sram_dat_i = 16'hBEEF;
        cyc();
        tests_run++;
        if (seen !== 1'b1 || sram_dat_oe !== 1'b0) begin
            tests_failed++; $display("FAIL wdrive_oe: got seen=%b oe=%b expected 1/0", seen, sram_dat_oe);
        end
        cyc();
        go_idle();
        cyc();
        model_write(7, 16'hBEEF, 1'b0, 1'b0);
        tests_run++;
        if (err_protocol !== 1'b0) begin tests_failed++; $display("FAIL wdrive_err: got %b expected 0", err_protocol); end
        do_read(18'd7, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (d !== 16'hBEEF) begin tests_failed++; $display("FAIL wdrive_data: got %h expected beef", d); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] d;
        sram_adr = 18'd10; sram_dat_i = 16'h5AA5; sram_lb = 1'b0; sram_ub = 1'b0;
        sram_ce = 1'b0; sram_we = 1'b0; sram_oe = 1'b0;
        cyc();
        cyc();
        sram_we = 1'b1;
        model_write(10, 16'h5AA5, 1'b0, 1'b0);
        lat = -1; d = '0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (sram_dat_oe) begin lat = i - 1; d = sram_dat_o; break; end
        end
        go_idle();
        cyc();
        tests_run++;
        if (lat !== READ_LAT || d !== 16'h5AA5) begin
            tests_failed++; $display("FAIL b2b_read: got lat=%0d %h expected lat=%0d 5aa5", lat, d, READ_LAT);
        end
    endtask

    task automatic test_err_and_reset();
        int lat; logic [15:0] d; logic seen;
        do_write(18'd8, 16'h1111, 1'b0, 1'b0, 1);
        sram_adr = 18'd8; sram_dat_i = 16'h2222; sram_lb = 1'b0; sram_ub = 1'b0;
        sram_ce = 1'b0; sram_we = 1'b0; sram_oe = 1'b1;
        cyc();
        sram_adr = 18'd9; sram_dat_i = 16'h3333;
        cyc();
        tests_run++;
        if (err_protocol !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b expected 1", err_protocol); end
        go_idle();
        cyc();
        model_write(8, 16'h3333, 1'b0, 1'b0);
        do_read(18'd8, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (d !== 16'h3333) begin tests_failed++; $display("FAIL err_commit: got %h expected 3333", d); end
        tests_run++;
        if (err_protocol !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err_protocol); end
        // Reset while driving read data
        sram_adr = 18'd8; sram_ce = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = sram_dat_oe; end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (seen !== 1'b1 || sram_dat_oe !== 1'b0 || sram_dat_o !== 16'h0000 || err_protocol !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got seen=%b oe=%b dat=%h err=%b expected 1/0/0000/0", seen, sram_dat_oe, sram_dat_o, err_protocol);
        end
        go_idle();
        cyc();
        reset_n = 1'b1;
        // Reset in the middle of a write aborts it
        sram_adr = 18'd8; sram_dat_i = 16'hDEAD; sram_ce = 1'b0; sram_we = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b0;
        cyc();
        go_idle();
        cyc();
        reset_n = 1'b1;
        cyc();
        do_read(18'd8, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (d !== 16'h3333 || lat !== READ_LAT) begin
            tests_failed++; $display("FAIL reset_abort: got lat=%0d %h expected lat=%0d 3333", lat, d, READ_LAT);
        end
    endtask

    task automatic test_random();
        int a, n, lat;
        logic [15:0] d, rd;
        logic lb, ub;
        logic [7:0] hi;
        for (int i = 16; i < 32; i++) do_write({8'h00, 10'(i)}, 16'($urandom), 1'b0, 1'b0, 1);
        for (int k = 0; k < 40; k++) begin
            a = 16 + int'($urandom_range(15, 0));
            hi = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                n = int'($urandom_range(3, 1));
                sram_adr = {hi, 10'(a)};
                sram_ce = 1'b0; sram_we = 1'b0; sram_oe = 1'($urandom);
                d = '0; lb = 1'b1; ub = 1'b1;
                for (int c = 0; c < n; c++) begin
                    d = 16'($urandom); lb = 1'($urandom); ub = 1'($urandom);
                    sram_dat_i = d; sram_lb = lb; sram_ub = ub;
                    cyc();
                end
                go_idle();
                cyc();
                model_write(a, d, lb, ub);
            end else begin
                lb = 1'($urandom); ub = 1'($urandom);
                do_read({hi, 10'(a)}, lb, ub, lat, rd);
                tests_run++;
                if (lat !== READ_LAT || rd !== model_read(a, lb, ub)) begin
                    tests_failed++;
                    $display("FAIL rand_read[%0d] addr %0d: got lat=%0d %h expected lat=%0d %h", k, a, lat, rd, READ_LAT, model_read(a, lb, ub));
                end
            end
        end
    endtask

`ifdef ZRB_SRAM_RESPONDER_STATS_EN
    task automatic test_stats();
        int lat; logic [15:0] d;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        do_write(18'd20, 16'h0020, 1'b0, 1'b0, 1);
        do_write(18'd21, 16'h0021, 1'b1, 1'b1, 2);
        do_write(18'd22, 16'h0022, 1'b0, 1'b0, 3);
        do_read(18'd20, 1'b0, 1'b0, lat, d);
        do_read(18'd22, 1'b0, 1'b0, lat, d);
        tests_run++;
        if (wr_count !== 16'd3 || rd_count !== 16'd2) begin
            tests_failed++; $display("FAIL stats_counts: got %0d/%0d expected 3/2", wr_count, rd_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_lanes();
        test_addr_change();
        test_write_in_drive();
        test_back_to_back();
        test_err_and_reset();
        test_random();
`ifdef ZRB_SRAM_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
